// File: rtl/pqvalue_invbfly.sv
// Pipelined Gentleman-Sande inverse-NTT butterfly: a' = (a+b) mod q, b' = ((a-b)*zeta) mod q.
// q is chosen per triple (Kyber 3329 or Dilithium 8380417); three-deep valid/ready pipe.
module pqvalue_invbfly #(
  parameter int W = 23
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic [W-1:0] zeta_i,
  input  logic         sel_red_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] a_o,
  output logic [W-1:0] b_o,
  output logic         red_o,
  output logic         busy_o
);

  localparam logic [W:0]     Q_KYB = (W+1)'(3329);
  localparam logic [W:0]     Q_DIL = (W+1)'(8380417);
  localparam logic [2*W+1:0] QK_L  = (2*W+2)'(3329);
  localparam logic [2*W+1:0] QD_L  = (2*W+2)'(8380417);

  function automatic logic [W-1:0] mod_add(input logic [W:0] x, input logic [W:0] y,
                                           input logic [W:0] q);
    logic [W:0] s;
    s = x + y;
    if (s >= q) s = s - q;
    return s[W-1:0];
  endfunction

  function automatic logic [W-1:0] mod_sub(input logic [W:0] x, input logic [W:0] y,
                                           input logic [W:0] q);
    logic [W:0] d;
    d = x - y;
    if (x < y) d = d + q;
    return d[W-1:0];
  endfunction

  // Plain product reduction, no Montgomery factor; both divisors are constants.
  function automatic logic [W-1:0] mod_mul(input logic [W:0] x, input logic [W:0] y,
                                           input logic sel);
    logic [2*W+1:0] p;
    logic [2*W+1:0] r;
    p = x * y;
    r = sel ? (p % QK_L) : (p % QD_L);
    return r[W-1:0];
  endfunction

  logic         vld_p0_q, vld_p0_d;
  logic         vld_p1_q, vld_p1_d;
  logic         vld_p2_q, vld_p2_d;
  logic [W-1:0] a_p0_q, b_p0_q, z_p0_q;
  logic         red_p0_q;
  logic [W-1:0] sum_p1_q, diff_p1_q, z_p1_q;
  logic         red_p1_q;
  logic [W-1:0] sum_p1_d, diff_p1_d, prod_p2_d;
  logic [W-1:0] a_p2_q, b_p2_q;
  logic         red_p2_q;
  logic [W:0]   q_p0;
  logic         in_fire, ld_p1, ld_p2;

  // Load enables ripple back from the output so a full pipe can shift and accept together.
  assign ld_p2      = vld_p1_q & (~vld_p2_q | out_ready_i);
  assign ld_p1      = vld_p0_q & (~vld_p1_q | ld_p2);
  assign in_ready_o = ~vld_p0_q | ld_p1;
  assign in_fire    = in_valid_i & in_ready_o;

  always_comb begin
    vld_p0_d = vld_p0_q;
    vld_p1_d = vld_p1_q;
    vld_p2_d = vld_p2_q;
    if (in_fire)          vld_p0_d = 1'b1;
    else if (ld_p1)       vld_p0_d = 1'b0;
    if (ld_p1)            vld_p1_d = 1'b1;
    else if (ld_p2)       vld_p1_d = 1'b0;
    if (ld_p2)            vld_p2_d = 1'b1;
    else if (out_ready_i) vld_p2_d = 1'b0;
  end

  // Stage 1: modular add/sub on the registered inputs.
  assign q_p0      = red_p0_q ? Q_KYB : Q_DIL;
  assign sum_p1_d  = mod_add({1'b0, a_p0_q}, {1'b0, b_p0_q}, q_p0);
  assign diff_p1_d = mod_sub({1'b0, a_p0_q}, {1'b0, b_p0_q}, q_p0);

  // Stage 2: twiddle multiply.
  assign prod_p2_d = mod_mul({1'b0, diff_p1_q}, {1'b0, z_p1_q}, red_p1_q);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_p0_q <= 1'b0;
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
      a_p2_q   <= '0;
      b_p2_q   <= '0;
      red_p2_q <= 1'b0;
    end else begin
      vld_p0_q <= vld_p0_d;
      vld_p1_q <= vld_p1_d;
      vld_p2_q <= vld_p2_d;
      if (ld_p2) begin
        a_p2_q   <= sum_p1_q;
        b_p2_q   <= prod_p2_d;
        red_p2_q <= red_p1_q;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (in_fire) begin
      a_p0_q   <= a_i;
      b_p0_q   <= b_i;
      z_p0_q   <= zeta_i;
      red_p0_q <= sel_red_i;
    end
    if (ld_p1) begin
      sum_p1_q  <= sum_p1_d;
      diff_p1_q <= diff_p1_d;
      z_p1_q    <= z_p0_q;
      red_p1_q  <= red_p0_q;
    end
  end

  assign out_valid_o = vld_p2_q;
  assign a_o         = a_p2_q;
  assign b_o         = b_p2_q;
  assign red_o       = red_p2_q;
  assign busy_o      = vld_p0_q | vld_p1_q | vld_p2_q;

endmodule

// File: tb/tb_pqvalue_invbfly.sv
// Directed bench for pqvalue_invbfly: known vectors, streaming, backpressure,
// random stalls against a reference scoreboard, and reset in mid-stream.
module tb_pqvalue_invbfly;
  localparam int W = 23;

  logic         clk = 1'b0;
  logic         rst_ni;
  logic         in_valid_i;
  logic         in_ready_o;
  logic [W-1:0] a_i, b_i, zeta_i;
  logic         sel_red_i;
  logic         out_valid_o;
  logic         out_ready_i;
  logic [W-1:0] a_o, b_o;
  logic         red_o;
  logic         busy_o;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] qa[$];
  logic [W-1:0] qb[$];
  logic         qr[$];

  pqvalue_invbfly #(.W(W)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .a_i(a_i), .b_i(b_i), .zeta_i(zeta_i), .sel_red_i(sel_red_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .a_o(a_o), .b_o(b_o), .red_o(red_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model in plain 64-bit integer arithmetic.
  task automatic push_exp(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] z, input logic sel);
    longint q, sa, sb;
    q  = sel ? 64'd3329 : 64'd8380417;
    sa = (longint'(a) + longint'(b)) % q;
    sb = (((longint'(a) - longint'(b) + q) % q) * longint'(z)) % q;
    qa.push_back(W'(sa));
    qb.push_back(W'(sb));
    qr.push_back(sel);
  endtask

  task automatic rand_in();
    int unsigned q;
    sel_red_i = 1'($urandom_range(1));
    q = sel_red_i ? 3329 : 8380417;
    a_i    = W'($urandom_range(q - 1));
    b_i    = W'($urandom_range(q - 1));
    zeta_i = W'($urandom_range(q - 1));
  endtask

  // Called 1 time unit after a rising edge; checks this cycle's handshakes, then advances.
  task automatic cyc(output bit in_fired);
    #1;
    if (out_valid_o && out_ready_i) begin
      chk("sb_nonempty", 64'(qa.size() != 0), 64'd1);
      if (qa.size() != 0) begin
        chk("sb_a", 64'(a_o), 64'(qa.pop_front()));
        chk("sb_b", 64'(b_o), 64'(qb.pop_front()));
        chk("sb_red", 64'(red_o), 64'(qr.pop_front()));
      end
    end
    in_fired = in_valid_i && in_ready_o;
    if (in_fired) push_exp(a_i, b_i, zeta_i, sel_red_i);
    @(posedge clk);
    #1;
  endtask

  task automatic directed(input string tag, input int a, input int b, input int z, input bit sel,
                          input int ea, input int eb);
    out_ready_i = 1'b1;
    in_valid_i  = 1'b1;
    a_i = W'(a); b_i = W'(b); zeta_i = W'(z); sel_red_i = sel;
    #1;
    chk({tag, "_in_ready"}, 64'(in_ready_o), 64'd1);
    @(posedge clk); #1;
    in_valid_i = 1'b0;
    chk({tag, "_vld_n1"}, 64'(out_valid_o), 64'd0);
    @(posedge clk); #1;
    chk({tag, "_vld_n2m"}, 64'(out_valid_o), 64'd0);
    @(posedge clk); #1;
    chk({tag, "_vld_n2"}, 64'(out_valid_o), 64'd1);
    chk({tag, "_a"}, 64'(a_o), 64'(ea));
    chk({tag, "_b"}, 64'(b_o), 64'(eb));
    chk({tag, "_red"}, 64'(red_o), 64'(sel));
    @(posedge clk); #1;
    chk({tag, "_drained"}, 64'(out_valid_o), 64'd0);
  endtask

  task automatic rand_run(input string tag, input int n, input int pin, input int pout,
                          output int iters);
    int sent;
    bit f;
    sent  = 0;
    iters = 0;
    in_valid_i = 1'b0;
    while ((sent < n || qa.size() != 0) && iters < 20 * n + 50) begin
      if (!in_valid_i && sent < n && $urandom_range(99) < pin) begin
        in_valid_i = 1'b1;
        rand_in();
      end
      out_ready_i = ($urandom_range(99) < pout);
      cyc(f);
      iters++;
      if (f) begin
        sent++;
        in_valid_i = 1'b0;
      end
    end
    chk({tag, "_sent"}, 64'(sent), 64'(n));
    chk({tag, "_drain"}, 64'(qa.size()), 64'd0);
  endtask

  initial begin
    int acc, iters;
    bit f;
    logic [W-1:0] hold_a, hold_b;

    rst_ni = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b1;
    a_i = '0; b_i = '0; zeta_i = '0; sel_red_i = 1'b0;
    #12;
    chk("rst_out_valid", 64'(out_valid_o), 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_a", 64'(a_o), 64'd0);
    chk("rst_b", 64'(b_o), 64'd0);
    chk("rst_red", 64'(red_o), 64'd0);
    @(negedge clk); rst_ni = 1'b1;
    @(posedge clk); #1;
    chk("rel_in_ready", 64'(in_ready_o), 64'd1);

    directed("kyber", 3000, 500, 17, 1'b1, 171, 2552);
    directed("dil_wrap", 5, 10, 1, 1'b0, 15, 8380412);
    directed("kyb_bound", 1, 3328, 2, 1'b1, 0, 4);
    directed("dil_max", 8380416, 8380416, 8380416, 1'b0, 8380415, 0);

    // Full-rate streaming: 64 triples take exactly 64 + 3 loop cycles.
    rand_run("stream", 64, 100, 100, iters);
    chk("stream_cycles", 64'(iters), 64'd67);

    // Backpressure: pipe holds exactly three triples.
    out_ready_i = 1'b0;
    in_valid_i  = 1'b1;
    rand_in();
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      cyc(f);
      if (f) begin
        acc++;
        rand_in();
      end
    end
    chk("bp_accepted", 64'(acc), 64'd3);
    chk("bp_in_ready", 64'(in_ready_o), 64'd0);
    chk("bp_out_valid", 64'(out_valid_o), 64'd1);
    chk("bp_busy", 64'(busy_o), 64'd1);
    hold_a = a_o;
    hold_b = b_o;
    in_valid_i = 1'b0;
    for (int i = 0; i < 3; i++) cyc(f);
    chk("bp_hold_a", 64'(a_o), 64'(hold_a));
    chk("bp_hold_b", 64'(b_o), 64'(hold_b));
    chk("bp_head_a", 64'(a_o), 64'(qa[0]));
    chk("bp_head_b", 64'(b_o), 64'(qb[0]));
    out_ready_i = 1'b1;
    for (int i = 0; i < 6; i++) cyc(f);
    chk("bp_drained", 64'(qa.size()), 64'd0);
    chk("bp_idle", 64'(busy_o), 64'd0);

    rand_run("stall", 1000, 50, 50, iters);

    // Reset with three triples in flight.
    out_ready_i = 1'b0;
    in_valid_i  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rand_in();
      @(posedge clk); #1;
    end
    in_valid_i = 1'b0;
    chk("mid_busy", 64'(busy_o), 64'd1);
    chk("mid_out_valid", 64'(out_valid_o), 64'd1);
    rst_ni = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(out_valid_o), 64'd0);
    chk("mid_rst_busy", 64'(busy_o), 64'd0);
    chk("mid_rst_a", 64'(a_o), 64'd0);
    chk("mid_rst_b", 64'(b_o), 64'd0);
    qa.delete(); qb.delete(); qr.delete();
    @(negedge clk); rst_ni = 1'b1;
    out_ready_i = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_valid", 64'(out_valid_o), 64'd0);
    @(posedge clk); #1;
    chk("post_rst_valid2", 64'(out_valid_o), 64'd0);
    directed("post_rst", 3000, 500, 17, 1'b1, 171, 2552);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
